// File: rtl/bht_update_engine_if.sv
// bht_update_engine_if: lookup and update-queue signals of the branch history table engine
interface bht_update_engine_if #(
   parameter int depth      = 32,
   parameter int fifo_depth = 4
);
   localparam int IW = $clog2(depth);
   localparam int PW = $clog2(fifo_depth) + 1;
   logic [IW-1:0] iLookupIndex;
   logic [1:0]    oLookupCounter;
   logic          oLookupPred;
   logic          iUpdValid;
   logic [IW-1:0] iUpdIndex;
   logic          iUpdTaken;
   logic          oUpdReady;
   logic          oBusy;
   logic [PW-1:0] oPending;
   modport master (
      output iLookupIndex, iUpdValid, iUpdIndex, iUpdTaken,
      input  oLookupCounter, oLookupPred, oUpdReady, oBusy, oPending
   );
   modport slave (
      input  iLookupIndex, iUpdValid, iUpdIndex, iUpdTaken,
      output oLookupCounter, oLookupPred, oUpdReady, oBusy, oPending
   );
endinterface

// File: rtl/bht_update_engine.sv
// bht_update_engine: 2-bit counter table with init sweep and serialized read-modify-write update queue
module bht_update_engine #(
   parameter int depth      = 32,
   parameter int fifo_depth = 4
) (
   input logic                iClk,
   input logic                iRst,
   bht_update_engine_if.slave bus
);
   localparam int IW = $clog2(depth);
   localparam int FW = $clog2(fifo_depth);
   typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
   state_t        r_state, w_next;
   logic [IW-1:0] r_sweep_ptr;
   logic [1:0]    r_table [depth];
   logic [IW-1:0] r_fifo_idx [fifo_depth];
   logic          r_fifo_tkn [fifo_depth];
   logic [FW-1:0] r_wr_ptr, r_rd_ptr;
   logic [FW:0]   r_count;
   logic [IW-1:0] r_upd_idx;
   logic          r_upd_tkn;
   logic [1:0]    r_upd_cnt;
   logic          w_full, w_push, w_pop, w_we;
   logic [IW-1:0] w_waddr;
   logic [1:0]    w_wdata, w_sat, w_lookup;

   assign w_full   = r_count == (FW+1)'(fifo_depth);
   assign w_push   = bus.iUpdValid && bus.oUpdReady;
   assign w_pop    = r_state == READ;
   assign w_sat    = r_upd_tkn ? ((r_upd_cnt == 2'b11) ? 2'b11 : r_upd_cnt + 2'b01)
                               : ((r_upd_cnt == 2'b00) ? 2'b00 : r_upd_cnt - 2'b01);
   assign w_we     = (r_state == INIT) || (r_state == WRITE);
   assign w_waddr  = (r_state == INIT) ? r_sweep_ptr : r_upd_idx;
   assign w_wdata  = (r_state == INIT) ? 2'b01 : w_sat;
   assign w_lookup = (r_state == INIT) ? 2'b01 : r_table[bus.iLookupIndex];

   assign bus.oLookupCounter = w_lookup;
   assign bus.oLookupPred    = w_lookup[1];
   assign bus.oUpdReady      = !w_full && (r_state != INIT);
   assign bus.oBusy          = r_state == INIT;
   assign bus.oPending       = r_count;

   // Next state: sweep until the last entry, then alternate READ/WRITE while the queue holds work
   always_comb begin
      w_next = r_state;
      case (r_state)
         INIT:    w_next = (r_sweep_ptr == IW'(depth - 1)) ? IDLE : INIT;
         IDLE:    w_next = (r_count != '0) ? READ : IDLE;
         READ:    w_next = WRITE;
         WRITE:   w_next = (r_count != '0) ? READ : IDLE;
         default: w_next = INIT;
      endcase
   end

   // Control state, queue pointers/occupancy and the latched update; reset drops all pending work
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         r_state     <= INIT;
         r_sweep_ptr <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_upd_idx   <= '0;
         r_upd_tkn   <= 1'b0;
         r_upd_cnt   <= 2'b01;
      end else begin
         r_state     <= w_next;
         r_sweep_ptr <= (r_state == INIT) ? r_sweep_ptr + 1'b1 : '0;
         r_wr_ptr    <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr    <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
         r_count     <= r_count + {{FW{1'b0}}, w_push} - {{FW{1'b0}}, w_pop};
         if (w_pop) begin
            r_upd_idx <= r_fifo_idx[r_rd_ptr];
            r_upd_tkn <= r_fifo_tkn[r_rd_ptr];
            r_upd_cnt <= r_table[r_fifo_idx[r_rd_ptr]];
         end
      end
   end

   // Storage arrays: counter table write port and queue tail write
   always_ff @(posedge iClk) begin
      if (w_we) r_table[w_waddr] <= w_wdata;
      if (w_push) begin
         r_fifo_idx[r_wr_ptr] <= bus.iUpdIndex;
         r_fifo_tkn[r_wr_ptr] <= bus.iUpdTaken;
      end
   end
endmodule
